// File: rtl/rx_sm.sv
// Ethernet receive state machine: preamble/SFD detect, FCS strip and check.
// Destination address filtering is compiled in with `define RX_ADDR_FILTER_EN.

module crc #(
    parameter logic [31:0] POLYNOMIAL = 32'h04C11DB7,
    parameter int          DATA_WIDTH = 8,
    parameter logic [31:0] SEED       = 32'hFFFFFFFF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  init,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [31:0]           crc_out
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    // MSB-first LFSR; data[DATA_WIDTH-1] enters first
    always_comb begin
        crc_d = crc_q;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            crc_d = {crc_d[30:0], 1'b0}
                  ^ ({32{crc_d[31] ^ data[i]}} & POLYNOMIAL);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            crc_q <= '0;
        end else if (init) begin
            crc_q <= SEED;
        end else if (enable) begin
            crc_q <= crc_d;
        end
    end

    assign crc_out = crc_q;

endmodule

module rx_sm #(
    parameter int          MIN_FRAME   = 64,
    parameter int          MAX_FRAME   = 1518,
    parameter logic [47:0] MAC_ADDRESS = 48'h00_00_00_00_00_01
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_data_valid,
    input  logic       rx_error,
    input  logic       fifo_full,
    output logic [7:0] fifo_data,
    output logic       fifo_data_write,
    output logic       fifo_data_start,
    output logic       fifo_data_end,
    output logic       fifo_frame_good,
    output logic       fifo_frame_bad
);

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        DATA,
        EOF,
        DROP
    } state_t;

    localparam logic [10:0] MIN_LEN = 11'(MIN_FRAME);
    localparam logic [10:0] MAX_END = 11'(MAX_FRAME + 1);

    state_t          state_q;
    logic [10:0]     cnt_q;
    logic [3:0][7:0] dly_q;
    logic            ovf_q;
    logic            started_q;
    logic            armed_q;
    logic [7:0]      data_q;
    logic            wr_q;
    logic            start_q;
    logic            end_q;
    logic            good_q;
    logic            bad_q;

    logic [10:0]     cnt_inc;
    logic            need_wr;
    logic            crc_init;
    logic            crc_en;
    logic            addr_ok;
    logic            frame_ok;
    logic [31:0]     crc_out;
    logic [31:0]     fcs_exp;

    function automatic logic [7:0] rev8(input logic [7:0] v);
        for (int i = 0; i < 8; i++) rev8[i] = v[7-i];
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] v);
        for (int i = 0; i < 32; i++) rev32[i] = v[31-i];
    endfunction

    assign cnt_inc  = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
    assign need_wr  = (state_q == DATA) && rx_data_valid
                   && (cnt_q >= 11'd4);
    assign crc_init = (state_q == PREAMBLE);
    assign crc_en   = need_wr && !fifo_full;

    // Bytes go on the wire LSB first, hence the reversal into the CRC
    crc #(
        .POLYNOMIAL(32'h04C11DB7),
        .DATA_WIDTH(8),
        .SEED      (32'hFFFFFFFF)
    ) u_crc (
        .clock  (clock),
        .reset  (reset),
        .init   (crc_init),
        .enable (crc_en),
        .data   (rev8(dly_q[0])),
        .crc_out(crc_out)
    );

    // dly_q[0] (oldest) sits in bits [7:0], matching FCS byte 0
    assign fcs_exp  = ~rev32(crc_out);
    assign frame_ok = (cnt_q >= MIN_LEN) && (cnt_q >= 11'd4) && !ovf_q
                   && addr_ok && (dly_q == fcs_exp);

`ifdef RX_ADDR_FILTER_EN
    localparam logic [5:0][7:0] MAC_BYTES = MAC_ADDRESS;

    logic       ucast_q;
    logic       bcast_q;
    logic [7:0] mac_byte;

    assign mac_byte = MAC_BYTES[3'd5 - cnt_q[2:0]];
    assign addr_ok  = ucast_q | bcast_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ucast_q <= 1'b0;
            bcast_q <= 1'b0;
        end else if (state_q != DATA) begin
            ucast_q <= 1'b1;
            bcast_q <= 1'b1;
        end else if (rx_data_valid && cnt_q < 11'd6) begin
            ucast_q <= ucast_q & (rx_data == mac_byte);
            bcast_q <= bcast_q & (rx_data == 8'hFF);
        end
    end
`else
    assign addr_ok = 1'b1;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dly_q     <= '0;
            ovf_q     <= 1'b0;
            started_q <= 1'b0;
            armed_q   <= 1'b0;
            data_q    <= '0;
            wr_q      <= 1'b0;
            start_q   <= 1'b0;
            end_q     <= 1'b0;
            good_q    <= 1'b0;
            bad_q     <= 1'b0;
        end else begin
            wr_q    <= 1'b0;
            start_q <= 1'b0;
            end_q   <= 1'b0;
            good_q  <= 1'b0;
            bad_q   <= 1'b0;
            // After reset, wait for a gap so a frame in flight is skipped
            if (!rx_data_valid) armed_q <= 1'b1;
            unique case (state_q)
                IDLE: begin
                    cnt_q     <= '0;
                    dly_q     <= '0;
                    ovf_q     <= 1'b0;
                    started_q <= 1'b0;
                    if (armed_q && rx_data_valid) begin
                        state_q <= (rx_data == 8'h55) ? PREAMBLE : DROP;
                    end
                end
                PREAMBLE: begin
                    if (!rx_data_valid) begin
                        state_q <= IDLE;
                    end else if (rx_data == 8'hD5) begin
                        state_q <= DATA;
                    end else if (rx_data != 8'h55) begin
                        state_q <= DROP;
                    end
                end
                DATA: begin
                    if (rx_data_valid) begin
                        cnt_q <= cnt_inc;
                        dly_q <= {rx_data, dly_q[3:1]};
                        if (need_wr) begin
                            if (fifo_full) begin
                                ovf_q <= 1'b1;
                            end else begin
                                wr_q      <= 1'b1;
                                data_q    <= dly_q[0];
                                start_q   <= !started_q;
                                started_q <= 1'b1;
                            end
                        end
                        if (rx_error || cnt_inc == MAX_END) begin
                            state_q <= DROP;
                        end
                    end else begin
                        state_q <= EOF;
                    end
                end
                EOF: begin
                    end_q   <= 1'b1;
                    good_q  <= frame_ok;
                    bad_q   <= !frame_ok;
                    state_q <= IDLE;
                end
                DROP: begin
                    if (!rx_data_valid) begin
                        end_q   <= started_q;
                        bad_q   <= started_q;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fifo_data       = data_q;
    assign fifo_data_write = wr_q;
    assign fifo_data_start = start_q;
    assign fifo_data_end   = end_q;
    assign fifo_frame_good = good_q;
    assign fifo_frame_bad  = bad_q;

endmodule

// File: tb/tb_rx_sm.sv
// Bench for rx_sm: random payloads with a reflected-CRC Ethernet model
// predicting FIFO writes, start/end strobes and the good/bad verdict.

module tb_rx_sm;

    localparam int MIN_FRAME = 64;
    localparam int MAX_FRAME = 1518;
    localparam logic [47:0] STATION = 48'h00_00_00_00_00_01;
    localparam logic [47:0] BCAST   = 48'hFF_FF_FF_FF_FF_FF;

    typedef logic [7:0] bq_t[$];

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_data_valid = 1'b0;
    logic       rx_error = 1'b0;
    logic       fifo_full = 1'b0;
    logic [7:0] fifo_data;
    logic       fifo_data_write;
    logic       fifo_data_start;
    logic       fifo_data_end;
    logic       fifo_frame_good;
    logic       fifo_frame_bad;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] got_q[$];
    int   n_start = 0;
    int   start_pos = 0;
    int   n_end = 0;
    int   n_odd = 0;
    logic seen_good = 1'b0;
    logic seen_bad = 1'b0;

    always #5 clock = ~clock;

    rx_sm dut (
        .clock          (clock),
        .reset          (reset),
        .rx_data        (rx_data),
        .rx_data_valid  (rx_data_valid),
        .rx_error       (rx_error),
        .fifo_full      (fifo_full),
        .fifo_data      (fifo_data),
        .fifo_data_write(fifo_data_write),
        .fifo_data_start(fifo_data_start),
        .fifo_data_end  (fifo_data_end),
        .fifo_frame_good(fifo_frame_good),
        .fifo_frame_bad (fifo_frame_bad)
    );

    // Collect what the FIFO would see
    always @(negedge clock) begin
        if (fifo_data_start) begin
            n_start++;
            start_pos = got_q.size();
            if (!fifo_data_write) n_odd++;
        end
        if (fifo_data_write) got_q.push_back(fifo_data);
        if (fifo_data_end) begin
            n_end++;
            seen_good = fifo_frame_good;
            seen_bad  = fifo_frame_bad;
            if (fifo_data_write) n_odd++;
            if (fifo_frame_good && fifo_frame_bad) n_odd++;
        end else if (fifo_frame_good || fifo_frame_bad) begin
            n_odd++;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        got_q.delete();
        n_start = 0;
        start_pos = 0;
        n_end = 0;
        n_odd = 0;
        seen_good = 1'b0;
        seen_bad = 1'b0;
    endtask

    function automatic logic [31:0] eth_fcs(input bq_t b, input int n);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c ^= {24'd0, b[i]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    function automatic bq_t make_frame(input int n, input logic [47:0] dst,
                                       input bit use_dst);
        bq_t f;
        logic [31:0] fcs;
        for (int i = 0; i < n; i++) begin
            if (use_dst && i < 6) f.push_back(dst[47-8*i -: 8]);
            else f.push_back(8'($urandom));
        end
        fcs = eth_fcs(f, n);
        for (int k = 0; k < 4; k++) f.push_back(fcs[8*k +: 8]);
        return f;
    endfunction

    task automatic drive(input bq_t fr, input int err_idx, input int full_idx);
        bq_t all;
        repeat (7) all.push_back(8'h55);
        all.push_back(8'hD5);
        foreach (fr[i]) all.push_back(fr[i]);
        for (int i = 0; i < all.size(); i++) begin
            @(negedge clock);
            rx_data_valid = 1'b1;
            rx_data   = all[i];
            rx_error  = (err_idx > 0) && (i - 7 == err_idx);
            fifo_full = (full_idx > 0) && (i - 7 == full_idx);
        end
        @(negedge clock);
        rx_data_valid = 1'b0;
        rx_data   = 8'h00;
        rx_error  = 1'b0;
        fifo_full = 1'b0;
    endtask

    // Data indices (err_idx, full_idx) count from 1 at the first byte after SFD
    task automatic run_frame(input string tag, input bq_t fr,
                             input int err_idx, input int full_idx);
        int total;
        int seen;
        int mism;
        int exp_end;
        bit drop;
        bit ovf;
        bit fcs_ok;
        bit dst_ok;
        bit exp_good;
        logic [47:0] dst;
        logic [31:0] fcs;
        logic [7:0] exp_q[$];
        total = fr.size();
        drop = 0;
        seen = total;
        if (total > MAX_FRAME) begin
            drop = 1;
            seen = MAX_FRAME + 1;
        end
        if (err_idx > 0 && err_idx <= seen) begin
            drop = 1;
            seen = err_idx;
        end
        for (int j = 1; j + 4 <= seen; j++) begin
            if (j != full_idx - 4) exp_q.push_back(fr[j-1]);
        end
        ovf = (full_idx > 4) && (full_idx <= seen);
        fcs_ok = 0;
        if (total >= 4) begin
            fcs = eth_fcs(fr, total - 4);
            fcs_ok = ({fr[total-1], fr[total-2], fr[total-3], fr[total-4]}
                      == fcs);
        end
        dst_ok = 1;
`ifdef RX_ADDR_FILTER_EN
        dst = '0;
        for (int i = 0; i < 6 && i < total; i++) dst[47-8*i -: 8] = fr[i];
        dst_ok = (total >= 6) && (dst == STATION || dst == BCAST);
`else
        dst = '0;
`endif
        exp_good = !drop && total >= MIN_FRAME && fcs_ok && !ovf && dst_ok;
        exp_end = drop ? int'(exp_q.size() > 0) : 1;

        clear_mon();
        drive(fr, err_idx, full_idx);
        repeat (8) @(negedge clock);

        check({tag, " writes"}, got_q.size(), exp_q.size());
        mism = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) mism++;
        end
        check({tag, " data"}, mism, 0);
        check({tag, " starts"}, n_start, int'(exp_q.size() > 0));
        if (n_start > 0) check({tag, " start_pos"}, start_pos, 0);
        check({tag, " ends"}, n_end, exp_end);
        if (exp_end == 1) begin
            check({tag, " good"}, int'(seen_good), int'(exp_good));
            check({tag, " bad"}, int'(seen_bad), int'(!exp_good));
        end
        check({tag, " strobes"}, n_odd, 0);
    endtask

    initial begin
        bq_t f;
        int n;
        int e;
        int u;
        int p;

        // Reset with a frame already on the wire
        reset = 1'b0;
        rx_data_valid = 1'b1;
        rx_data = 8'h55;
        repeat (3) @(negedge clock);
        check("reset outputs",
              {fifo_data, fifo_data_write, fifo_data_start, fifo_data_end,
               fifo_frame_good, fifo_frame_bad}, 0);
        clear_mon();
        reset = 1'b1;
        f = make_frame(60, STATION, 1);
        drive(f, 0, 0);
        repeat (8) @(negedge clock);
        check("post-reset ignore writes", got_q.size(), 0);
        check("post-reset ignore ends", n_end, 0);

        run_frame("good60", make_frame(60, STATION, 1), 0, 0);

        f = make_frame(60, STATION, 1);
        f[62] = f[62] ^ 8'h10;
        run_frame("fcs flip", f, 0, 0);

        run_frame("runt20", make_frame(20, STATION, 1), 0, 0);
        run_frame("len63", make_frame(59, STATION, 1), 0, 0);
        run_frame("err30", make_frame(60, STATION, 1), 30, 0);
        run_frame("full40", make_frame(60, STATION, 1), 0, 40);

        f.delete();
        f.push_back(8'($urandom));
        f.push_back(8'($urandom));
        run_frame("short2", f, 0, 0);

        run_frame("max1518", make_frame(1514, STATION, 1), 0, 0);
        run_frame("over1525", make_frame(1521, STATION, 1), 0, 0);

        for (int r = 0; r < 5; r++) begin
            n = $urandom_range(1, 120);
            f = make_frame(n, {16'h0, 32'($urandom)}, 0);
            if ($urandom_range(0, 3) == 0) begin
                p = $urandom_range(0, f.size() - 1);
                f[p] = f[p] ^ (8'h01 << $urandom_range(0, 7));
            end
            e = ($urandom_range(0, 4) == 0) ? $urandom_range(1, f.size()) : 0;
            u = ($urandom_range(0, 4) == 0) ? $urandom_range(1, f.size()) : 0;
            run_frame("random", f, e, u);
        end

        // Reset in the middle of a frame must not produce an end strobe
        clear_mon();
        f = make_frame(60, STATION, 1);
        for (int i = 0; i < 28; i++) begin
            @(negedge clock);
            rx_data_valid = 1'b1;
            rx_data = (i < 7) ? 8'h55 : ((i == 7) ? 8'hD5 : f[i-8]);
        end
        reset = 1'b0;
        @(negedge clock);
        check("midreset outputs",
              {fifo_data, fifo_data_write, fifo_data_start, fifo_data_end,
               fifo_frame_good, fifo_frame_bad}, 0);
        rx_data_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        repeat (6) @(negedge clock);
        check("midreset ends", n_end, 0);

        run_frame("after reset", make_frame(64, STATION, 1), 0, 0);

`ifdef RX_ADDR_FILTER_EN
        run_frame("dst other", make_frame(60, 48'h00_00_00_00_00_02, 1), 0, 0);
        run_frame("dst bcast", make_frame(60, BCAST, 1), 0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_sm.md
RX_SM -- requirements
Module: rx_sm

Interface
REQ-001 SHALL have parameter MIN_FRAME, default 64: minimum legal frame bytes after SFD, FCS included.
REQ-002 SHALL have parameter MAX_FRAME, default 1518: maximum legal frame bytes after SFD, FCS included.
REQ-003 SHALL have parameter MAC_ADDRESS, default 48'h00_00_00_00_00_01: station address, used only under RX_ADDR_FILTER_EN.
REQ-004 SHALL have port clock, input, 1: single clock; all logic rising-edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port rx_data, input, 8: received byte from PHY.
REQ-007 SHALL have port rx_data_valid, input, 1: rx_data valid this cycle; low marks end of carrier.
REQ-008 SHALL have port rx_error, input, 1: PHY symbol error this cycle.
REQ-009 SHALL have port fifo_full, input, 1: receive FIFO cannot accept a write.
REQ-010 SHALL have port fifo_data, output, 8: byte to FIFO.
REQ-011 SHALL have port fifo_data_write, output, 1: write strobe for fifo_data.
REQ-012 SHALL have port fifo_data_start, output, 1: marks first written byte of a frame.
REQ-013 SHALL have port fifo_data_end, output, 1: one-cycle end-of-frame strobe, never coincident with fifo_data_write.
REQ-014 SHALL have port fifo_frame_good, output, 1: with fifo_data_end, frame accepted.
REQ-015 SHALL have port fifo_frame_bad, output, 1: with fifo_data_end, FIFO discards frame.

Function
REQ-016 SHALL implement states IDLE, PREAMBLE, DATA, EOF, DROP.
REQ-017 IDLE: valid && rx_data==8'h55 -> PREAMBLE; valid && other byte -> DROP; else stay.
REQ-018 PREAMBLE: !valid -> IDLE; rx_data==8'hD5 -> DATA; 8'h55 -> stay; other byte -> DROP.
REQ-019 DATA: each valid byte shifts into 4-byte delay line and increments 11-bit frame_length_count (saturating at 2047).
REQ-020 DATA: when valid and count (pre-increment) >= 4, oldest delay byte SHALL be written (fifo_data_write=1); first such write per frame also asserts fifo_data_start; FCS bytes never written.
REQ-021 Latency: received byte written to FIFO on the 4th subsequent valid DATA cycle.
REQ-022 CRC SHALL use crc submodule (POLYNOMIAL 32'h04C11DB7, DATA_WIDTH 8, SEED 32'hFFFFFFFF), init asserted in PREAMBLE, enabled on each FIFO-written byte.
REQ-023 DATA: !valid -> EOF; rx_error or count reaching MAX_FRAME+1 -> DROP.
REQ-024 EOF (one cycle): fifo_data_end=1; good iff count >= MIN_FRAME, no overflow, and delay byte k (k=0 oldest) equals bitwise-inverted bit-reversed crc_out bits [8k+7:8k], k=0..3; else fifo_frame_bad=1; -> IDLE.
REQ-025 DATA with fifo_full on a required write: write suppressed, overflow flag set, frame ends bad.
REQ-026 DROP: wait for !valid; on exit, if fifo_data_start was issued this frame, fifo_data_end=1 and fifo_frame_bad=1; -> IDLE.
REQ-027 Frame under 4 bytes reaching EOF SHALL emit end with bad, never start.
REQ-028 frame_length_count, delay line, overflow flag cleared in IDLE.

Reset
REQ-029 reset low SHALL immediately force state IDLE, counters/delay line/flags zero, all outputs 0.
REQ-030 reset mid-frame SHALL emit no fifo_data_end; FIFO clears partial frames on the same reset.
REQ-031 After reset release, rx_sm SHALL ignore bytes until rx_data_valid low for one cycle.

Configuration
REQ-032 With RX_ADDR_FILTER_EN defined: first 6 data bytes compared to MAC_ADDRESS (first byte = bits [47:40]) and FF:FF:FF:FF:FF:FF; neither match -> frame ends bad at EOF.
REQ-033 Without RX_ADDR_FILTER_EN: no address comparison; MAC_ADDRESS unused.

Verification
REQ-034 7x55, D5, 60 data bytes, correct 4-byte FCS -> 60 writes, start on first, one end with good.
REQ-035 Same frame, one FCS bit flipped -> 60 writes, end with bad.
REQ-036 7x55, D5, 20 data bytes, FCS (24 total) -> end with bad (runt).
REQ-037 rx_error on 30th data byte -> DROP, 26 writes, end with bad after valid falls.
REQ-038 fifo_full high for one write cycle mid-frame -> that byte not written, end with bad.
REQ-039 RX_ADDR_FILTER_EN, dest 00:00:00:00:00:02 valid FCS -> bad; dest broadcast -> good.
